// File: rtl/seg_display_scheduler_pkg.sv
// seg_pkg: shared types, widths and the BCD digit-adjust helper for the display scheduler
package seg_pkg;
  localparam int BIN_W = 12;
  localparam int BCD_DIGITS = 4;
  typedef enum logic [2:0] {IDLE, GRANT, CONV, SHOW, HOLD} state_t;
  typedef logic [BCD_DIGITS-1:0][3:0] bcd_digits_t;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/seg_display_scheduler_if.sv
// seg_display_scheduler_if: valid/ready request bus from the value producers
interface seg_display_scheduler_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0] req_valid;
  logic [12*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  modport master (output req_valid, output req_data, input req_ready);
  modport slave (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/seg_display_scheduler_bin2bcd_seq.sv
// bin2bcd_seq: shift-add-3 binary to BCD converter, one bit per cycle
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [15:0]      bcd
);
  logic [27:0] sr, nxt;
  logic [3:0] cnt;
  logic active;
  assign nxt = {add3(sr[27:24]), add3(sr[23:20]), add3(sr[19:16]), add3(sr[15:12]), sr[11:0]} << 1;
  // bcd presents the result of the iteration in progress so done and bcd line up on the 12th cycle
  assign bcd = nxt[27:12];
  assign done = active && cnt == 4'd11;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      active <= 1'b0;
    end else if (start) begin
      sr <= {16'b0, bin};
      cnt <= '0;
      active <= 1'b1;
    end else if (active) begin
      sr <= nxt;
      cnt <= cnt + 4'd1;
      active <= !done;
    end
  end
endmodule

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin sharing of the 4-digit display with BCD conversion and dwell
module seg_display_scheduler
  import seg_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg_display_scheduler_if.slave  req,
  output bcd_digits_t             bcd_out,
  output logic [3:0]              blank_mask,
  output logic                    disp_valid,
  output logic [1:0]              owner,
  output logic                    busy
);
  localparam int CW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  state_t state, state_nxt;
  logic [1:0] win, last_owner, pick;
  logic [3:0] valid4, mask;
  logic [47:0] data4;
  logic [BIN_W-1:0] sel_data;
  logic [CW-1:0] dwell;
  logic any_req, last_dwell, start, done, found;
  bcd_digits_t conv_bcd;
  assign valid4 = 4'(req.req_valid);
  assign data4 = 48'(req.req_data);
  assign any_req = |valid4;
  assign last_dwell = dwell == '0;
  assign sel_data = win == 2'd0 ? data4[11:0] : win == 2'd1 ? data4[23:12] : win == 2'd2 ? data4[35:24] : data4[47:36];
  // unused requester slots read as zero, so a mod-4 rotation is a correct mod-NUM_REQ rotation
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && valid4[last_owner + 2'(k)]) begin
        found = 1'b1;
        pick = last_owner + 2'(k);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HOLD: state_nxt = any_req ? GRANT : state;
      GRANT:      state_nxt = CONV;
      CONV:       state_nxt = done ? SHOW : CONV;
      SHOW:       state_nxt = last_dwell ? (any_req ? GRANT : HOLD) : SHOW;
      default:    state_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state == GRANT || state == CONV;
    start = state == GRANT;
    req.req_ready = start ? NUM_REQ'(1) << win : '0;
  end
  bin2bcd_seq u_conv (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bin  (sel_data),
    .done (done),
    .bcd  (conv_bcd)
  );
  always_comb begin
    mask[3] = conv_bcd[3] == 4'd0;
    mask[2] = mask[3] && conv_bcd[2] == 4'd0;
    mask[1] = mask[2] && conv_bcd[1] == 4'd0;
    mask[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
      last_owner <= 2'(NUM_REQ - 1);
      dwell <= '0;
      bcd_out <= '0;
      blank_mask <= 4'b1110;
      disp_valid <= 1'b0;
      owner <= '0;
    end else begin
      if (state_nxt == GRANT) win <= pick;
      if (start) last_owner <= win;
      if (done) begin
        bcd_out <= conv_bcd;
        blank_mask <= mask;
        disp_valid <= 1'b1;
        owner <= win;
        dwell <= CW'(DWELL_CYCLES - 1);
      end else if (state == SHOW && !last_dwell) begin
        dwell <= dwell - CW'(1);
      end
    end
  end
endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Shares the 4-digit seven-segment display between up to four requesters, each offering a 12-bit binary value through a valid/ready handshake. Uses round-robin arbitration and converts the winning value to BCD with a sequential shift-add-3 engine, one bit per cycle. Holds each result on the display for a minimum dwell time and computes a leading-zero blank mask. Sits between the value producers and the display path: the existing anode scanner and segment decoder consume `bcd_out` and `blank_mask`.

## Interface
- `NUM_REQ`, 2: number of requesters, legal range 2..4.
- `DWELL_CYCLES`, 50_000_000: minimum cycles a converted value stays displayed (0.5 s at 100 MHz). Legal range ≥1.
- `clk` in 1: 100 MHz system clock. Every flop is clocked on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in NUM_REQ: bit i means requester i offers a value.
- `req_data` in 12*NUM_REQ: requester i's value, at bits [12i+11:12i].
- `req_ready` out NUM_REQ: one-hot, one-cycle accept pulse.
- `bcd_out` out 16: {thousands, hundreds, tens, ones}.
- `blank_mask` out 4: bit i=1 blanks digit i. Bit 0 is always 0.
- `disp_valid` out 1: `bcd_out` holds a converted value.
- `owner` out 2: index of the requester whose value is displayed.
- `busy` out 1: high in GRANT or CONV.

## Operation
- The FSM has five states: IDLE, GRANT, CONV, SHOW, HOLD.
- IDLE (reset state), nothing shown yet:
  - If any `req_valid` is high, pick a winner and go to GRANT.
- GRANT:
  - `req_ready[winner]` is high for exactly this one cycle. It is a Moore output.
  - At the closing edge, latch `req_data[winner]` and the winner index, then go to CONV.
- CONV: 12 iterations on a 28-bit shift register, one per cycle:
  - Add 3 to each of the four BCD nibbles that is ≥5.
  - Then shift left by 1.
  - After the 12th iteration, update `bcd_out`, `blank_mask` and `owner`, set `disp_valid`=1, load the dwell counter, and go to SHOW.
- SHOW: counts down exactly DWELL_CYCLES cycles. In the last cycle:
  - If any `req_valid` is high, pick a winner and go to GRANT.
  - Otherwise go to HOLD.
- HOLD: keeps the current value.
  - On any `req_valid`, pick a winner and go to GRANT.
- Arbitration is round-robin:
  - The search starts at (last_owner+1) mod NUM_REQ.
  - After reset, last_owner = NUM_REQ-1, so requester 0 has first priority.
- Display outputs change only at the CONV→SHOW edge. The old value stays displayed through GRANT and CONV, so there is no flicker.
- Blank mask:
  - Bit 3 = (thousands==0).
  - Bit 2 = bit3 & (hundreds==0).
  - Bit 1 = bit2 & (tens==0).
  - Bit 0 = 0.
- Handshake rule: a requester must hold `req_valid` and `req_data` stable until it sees `req_ready` high. Withdrawing a request before then is illegal, and the bench flags it.
- `req_valid` is ignored in GRANT and CONV, and in SHOW except in its last cycle.
- Reset values: `req_ready`=0, `bcd_out`=0, `blank_mask`=4'b1110, `disp_valid`=0, `owner`=0, `busy`=0, state IDLE, last_owner=NUM_REQ-1.

## Timing
- Cycle n: `req_valid` is sampled high in IDLE or HOLD.
  - n+1: GRANT, `req_ready` high.
  - n+2..n+13: CONV.
  - n+14: new `bcd_out`, `blank_mask` and `owner` are visible.
  - Latency from request to display is 14 cycles.
- From SHOW, back-to-back throughput is one value per DWELL_CYCLES+13 cycles.
- Simultaneous requests: only the winner gets `req_ready`. The losers stay pending and win in later rounds in rotation.
- Reset mid-CONV or mid-GRANT: the latched value is dropped and no `req_ready` is issued afterwards. The requester keeps `req_valid` high and is served after reset in normal priority order.
- Boundary values:
  - Dwell counter: DWELL_CYCLES=1 makes SHOW last exactly one cycle.
  - Conversion input 0: `bcd_out`=0x0000, `blank_mask`=1110.
  - Conversion input 4095: `bcd_out`=0x4095, `blank_mask`=0000.

## Structure
- Package `seg_pkg` holds:
  - the state enum;
  - `BIN_W`=12 and `BCD_DIGITS`=4;
  - the `bcd_digits_t` typedef (4×4-bit).
- Sub-module `bin2bcd_seq`:
  - Ports: `start`, `bin[11:0]`, `done` (one-cycle pulse), `bcd[15:0]`.
  - Contains the CONV shift register and the 4-bit iteration counter.
- The top level holds the FSM, the arbiter, the dwell counter and the blank logic.

## Test plan
- Reset, then req0 with value 1234, DWELL_CYCLES=20 → `req_ready`=01 at n+1; `bcd_out`=0x1234, `blank_mask`=0000, `owner`=0, `disp_valid`=1 at n+14.
- Values 0, 7, 100, 4095 in sequence → `bcd_out`=0x0000/0x0007/0x0100/0x4095; `blank_mask`=1110/1110/1000/0000.
- req0 and req1 held together continuously → grants alternate 0,1,0,1; each value stays for exactly 20 cycles plus 13; `owner` tracks the grants.
- Request arrives in mid-SHOW → no `req_ready` until the last dwell cycle; GRANT follows the next cycle; the old value is displayed until the new one is ready.
- `rst_n` low in CONV cycle 5 → all outputs at reset values immediately (asynchronously); after release, the held request is re-granted and converted correctly.
- NUM_REQ=4, all requesting → grant order 0,1,2,3,0; `req_ready` is one-hot every time.
